// File: rtl/xil_mem_sp_arb_1024x18.sv
// Two-port arbiter/sequencer in front of a single-port 1024x18 read-first BRAM with 9-bit lanes.
// Optional power-up clear engine enabled by defining XIL_MEM_SP_ARB_CLEAR_EN.
module xil_mem_sp_arb_1024x18 #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter logic [17:0] INIT_VALUE = 18'h00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_a_req,
    output logic        o_a_gnt,
    input  logic [1:0]  i_a_wen,
    input  logic [9:0]  i_a_adr,
    input  logic [17:0] i_a_wdata,
    output logic        o_a_rvalid,
    output logic [17:0] o_a_rdata,
    input  logic        i_b_req,
    output logic        o_b_gnt,
    input  logic [1:0]  i_b_wen,
    input  logic [9:0]  i_b_adr,
    input  logic [17:0] i_b_wdata,
    output logic        o_b_rvalid,
    output logic [17:0] o_b_rdata,
    output logic        o_mem_en,
    output logic [1:0]  o_mem_wen,
    output logic [9:0]  o_mem_adr,
    output logic [17:0] o_mem_wdata,
    input  logic [17:0] i_mem_rdata,
    output logic        o_busy
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 18;
    localparam int unsigned LW = 2;
    localparam logic [AW-1:0] LAST_ADR = '1;

    logic          busy;
    logic [AW-1:0] clr_cnt;
    logic          last_a;
    logic          win_a;
    logic          win_b;
    logic          gnt_any;
    logic [LW-1:0] sel_wen;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wdata;
    logic          s1_owner;
    logic          s1_rd;
    logic          s2_valid;
    logic          s2_owner;

`ifdef XIL_MEM_SP_ARB_CLEAR_EN
    // Clear engine: walks every address once after reset, then parks at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b1;
            clr_cnt <= '0;
        end else if (busy) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == LAST_ADR) begin
                busy <= 1'b0;
            end
        end
    end
`else
    assign busy    = 1'b0;
    assign clr_cnt = '0;
`endif

    assign o_busy = busy;

    // Arbitration: last_a set means A was granted most recently, so B wins a tie
    always_comb begin
        win_a = i_a_req && ((FIXED_PRIO != 0) || !i_b_req || !last_a);
        win_b = i_b_req && !win_a;
    end

    assign o_a_gnt = win_a && !busy;
    assign o_b_gnt = win_b && !busy;
    assign gnt_any = o_a_gnt || o_b_gnt;

    always_comb begin
        sel_wen   = i_a_wen;
        sel_adr   = i_a_adr;
        sel_wdata = i_a_wdata;
        if (o_b_gnt) begin
            sel_wen   = i_b_wen;
            sel_adr   = i_b_adr;
            sel_wdata = i_b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a <= 1'b0;
        end else if (o_a_gnt) begin
            last_a <= 1'b1;
        end else if (o_b_gnt) begin
            last_a <= 1'b0;
        end
    end

    // Stage 1: registered memory command plus owner/read tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_mem_en    <= 1'b0;
            o_mem_wen   <= '0;
            o_mem_adr   <= '0;
            o_mem_wdata <= '0;
            s1_owner    <= 1'b0;
            s1_rd       <= 1'b0;
        end else if (busy) begin
            o_mem_en    <= 1'b1;
            o_mem_wen   <= '1;
            o_mem_adr   <= clr_cnt;
            o_mem_wdata <= INIT_VALUE;
            s1_owner    <= 1'b0;
            s1_rd       <= 1'b0;
        end else begin
            o_mem_en <= gnt_any;
            s1_owner <= o_b_gnt;
            if (gnt_any) begin
                o_mem_wen   <= sel_wen;
                o_mem_adr   <= sel_adr;
                o_mem_wdata <= sel_wdata;
                s1_rd       <= (sel_wen == '0);
            end else begin
                o_mem_wen <= '0;
                s1_rd     <= 1'b0;
            end
        end
    end

    // Stage 2: BRAM output is valid the cycle after the enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_owner <= 1'b0;
        end else begin
            s2_valid <= o_mem_en && s1_rd;
            s2_owner <= s1_owner;
        end
    end

    // Response: capture into the owner's data register and pulse its valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a_rvalid <= 1'b0;
            o_a_rdata  <= '0;
            o_b_rvalid <= 1'b0;
            o_b_rdata  <= '0;
        end else begin
            o_a_rvalid <= s2_valid && !s2_owner;
            o_b_rvalid <= s2_valid && s2_owner;
            if (s2_valid && !s2_owner) begin
                o_a_rdata <= i_mem_rdata;
            end
            if (s2_valid && s2_owner) begin
                o_b_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_xil_mem_sp_arb_1024x18.sv
// Bench for xil_mem_sp_arb_1024x18: word-level memory/arbitration model with directed and random traffic.
`timescale 1ns/1ps
module tb_xil_mem_sp_arb_1024x18;

    localparam logic [17:0] INIT = 18'h2AAAA;
`ifdef XIL_MEM_SP_ARB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        int          gap;
        logic [1:0]  wen;
        logic [9:0]  adr;
        logic [17:0] wdata;
    } txn_t;

    typedef struct {
        int          due;
        logic [17:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req [2];
    logic [1:0]  wen [2];
    logic [9:0]  adr [2];
    logic [17:0] wdata [2];

    logic        o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_mem_en, o_busy;
    logic [17:0] o_a_rdata, o_b_rdata, o_mem_wdata, mem_rdata;
    logic [1:0]  o_mem_wen;
    logic [9:0]  o_mem_adr;

    logic        f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_mem_en, f_busy;
    logic [17:0] f_a_rdata, f_b_rdata, f_mem_wdata;
    logic [1:0]  f_mem_wen;
    logic [9:0]  f_mem_adr;
    logic [17:0] zero18 = '0;

    always #5 clk = ~clk;

    xil_mem_sp_arb_1024x18 #(.FIXED_PRIO(0), .INIT_VALUE(INIT)) dut (
        .clk(clk), .rst(rst),
        .i_a_req(req[0]), .o_a_gnt(o_a_gnt), .i_a_wen(wen[0]), .i_a_adr(adr[0]),
        .i_a_wdata(wdata[0]), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
        .i_b_req(req[1]), .o_b_gnt(o_b_gnt), .i_b_wen(wen[1]), .i_b_adr(adr[1]),
        .i_b_wdata(wdata[1]), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
        .o_mem_en(o_mem_en), .o_mem_wen(o_mem_wen), .o_mem_adr(o_mem_adr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(o_busy)
    );

    // Fixed-priority instance sees the same requests; only its grants are checked
    xil_mem_sp_arb_1024x18 #(.FIXED_PRIO(1), .INIT_VALUE(INIT)) dut_fp (
        .clk(clk), .rst(rst),
        .i_a_req(req[0]), .o_a_gnt(f_a_gnt), .i_a_wen(wen[0]), .i_a_adr(adr[0]),
        .i_a_wdata(wdata[0]), .o_a_rvalid(f_a_rvalid), .o_a_rdata(f_a_rdata),
        .i_b_req(req[1]), .o_b_gnt(f_b_gnt), .i_b_wen(wen[1]), .i_b_adr(adr[1]),
        .i_b_wdata(wdata[1]), .o_b_rvalid(f_b_rvalid), .o_b_rdata(f_b_rdata),
        .o_mem_en(f_mem_en), .o_mem_wen(f_mem_wen), .o_mem_adr(f_mem_adr),
        .o_mem_wdata(f_mem_wdata), .i_mem_rdata(zero18), .o_busy(f_busy)
    );

    // Read-first BRAM with two 9-bit lanes
    logic [17:0] bram [1024];
    always @(posedge clk) begin
        if (o_mem_en) begin
            mem_rdata <= bram[o_mem_adr];
            if (o_mem_wen[0]) bram[o_mem_adr][8:0]  <= o_mem_wdata[8:0];
            if (o_mem_wen[1]) bram[o_mem_adr][17:9] <= o_mem_wdata[17:9];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [17:0] ref_mem [1024];
    txn_t        txq_a[$], txq_b[$];
    rsp_t        rq_a[$], rq_b[$];
    txn_t        cur [2];
    bit          have [2];
    bit          eg [2];
    bit          sg [2];
    bit          last_a;
    int          cyc;
    bit          exp_en;
    logic [1:0]  exp_wen;
    logic [9:0]  exp_adr;
    logic [17:0] exp_wdata;
    logic [17:0] hold_a, hold_b;
    bit          log_on = 1'b0;
    int          glog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input int gap, input logic [1:0] w, input logic [9:0] a,
                        input logic [17:0] d);
        txn_t t;
        t.gap = gap; t.wen = w; t.adr = a; t.wdata = d;
        if (p == 0) txq_a.push_back(t);
        else        txq_b.push_back(t);
    endtask

    function automatic bit idle();
        return txq_a.size() == 0 && txq_b.size() == 0 && !have[0] && !have[1] &&
               !req[0] && !req[1] && rq_a.size() == 0 && rq_b.size() == 0;
    endfunction

    task automatic wait_idle(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            #1;
            done = idle();
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    // Reference model: updates memory image and response schedule at each clock edge, then drives requesters
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            bram[i]    = '0;
        end
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; wen[p] = '0; adr[p] = '0; wdata[p] = '0; have[p] = 1'b0;
        end
        cyc = 0; last_a = 1'b0; exp_en = 1'b0; exp_wen = '0; exp_adr = '0; exp_wdata = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc = 0; last_a = 1'b0;
                rq_a.delete(); rq_b.delete();
                exp_en = 1'b0; exp_wen = '0; exp_adr = '0; exp_wdata = '0;
                if (CLR) for (int i = 0; i < 1024; i++) ref_mem[i] = INIT;
            end else begin
                cyc++;
                exp_en = 1'b0; exp_wen = '0;
                if (CLR && cyc >= 1 && cyc <= 1024) begin
                    exp_en = 1'b1; exp_wen = 2'b11; exp_adr = 10'(cyc - 1); exp_wdata = INIT;
                end
                for (int p = 0; p < 2; p++) begin
                    if (eg[p]) begin
                        if (wen[p] == 2'b00) begin
                            rsp_t r;
                            r.due = cyc + 2; r.data = ref_mem[adr[p]];
                            if (p == 0) rq_a.push_back(r);
                            else        rq_b.push_back(r);
                        end else begin
                            if (wen[p][0]) ref_mem[adr[p]][8:0]  = wdata[p][8:0];
                            if (wen[p][1]) ref_mem[adr[p]][17:9] = wdata[p][17:9];
                        end
                        exp_en = 1'b1; exp_wen = wen[p]; exp_adr = adr[p]; exp_wdata = wdata[p];
                        last_a = (p == 0);
                    end
                end
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                if (rst) begin
                    req[p] = 1'b0; have[p] = 1'b0;
                end else begin
                    if (req[p] && sg[p]) begin
                        req[p] = 1'b0; have[p] = 1'b0;
                    end
                    if (!have[p]) begin
                        if (p == 0 && txq_a.size() > 0) begin
                            cur[p] = txq_a.pop_front(); have[p] = 1'b1;
                        end else if (p == 1 && txq_b.size() > 0) begin
                            cur[p] = txq_b.pop_front(); have[p] = 1'b1;
                        end
                    end
                    if (have[p] && !req[p]) begin
                        if (cur[p].gap > 0) cur[p].gap--;
                        else begin
                            req[p] = 1'b1; wen[p] = cur[p].wen; adr[p] = cur[p].adr; wdata[p] = cur[p].wdata;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    initial begin
        bit exp_busy, wa, wb, ev_a, ev_b;
        hold_a = '0; hold_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                eg[0] = 1'b0; eg[1] = 1'b0; sg[0] = 1'b0; sg[1] = 1'b0;
                hold_a = '0; hold_b = '0;
                chk("rst_mem_en", 32'(o_mem_en), 32'd0);
                chk("rst_mem_wen", 32'(o_mem_wen), 32'd0);
                chk("rst_mem_adr", 32'(o_mem_adr), 32'd0);
                chk("rst_rvalid", 32'({o_a_rvalid, o_b_rvalid}), 32'd0);
                chk("rst_rdata", 32'(o_a_rdata | o_b_rdata), 32'd0);
                chk("rst_busy", 32'(o_busy), 32'(CLR));
            end else begin
                exp_busy = CLR && (cyc < 1024);
                wa = req[0] && (!req[1] || !last_a);
                wb = req[1] && !wa;
                eg[0] = wa && !exp_busy;
                eg[1] = wb && !exp_busy;
                sg[0] = o_a_gnt; sg[1] = o_b_gnt;
                if (log_on && (o_a_gnt || o_b_gnt)) glog.push_back(o_b_gnt ? 1 : 0);
                chk("busy", 32'(o_busy), 32'(exp_busy));
                chk("a_gnt", 32'(o_a_gnt), 32'(eg[0]));
                chk("b_gnt", 32'(o_b_gnt), 32'(eg[1]));
                chk("fp_a_gnt", 32'(f_a_gnt), 32'(req[0] && !exp_busy));
                chk("fp_b_gnt", 32'(f_b_gnt), 32'(req[1] && !req[0] && !exp_busy));
                chk("mem_en", 32'(o_mem_en), 32'(exp_en));
                chk("mem_wen", 32'(o_mem_wen), 32'(exp_wen));
                chk("mem_adr", 32'(o_mem_adr), 32'(exp_adr));
                chk("mem_wdata", 32'(o_mem_wdata), 32'(exp_wdata));
                ev_a = rq_a.size() > 0 && rq_a[0].due == cyc;
                ev_b = rq_b.size() > 0 && rq_b[0].due == cyc;
                chk("a_rvalid", 32'(o_a_rvalid), 32'(ev_a));
                chk("b_rvalid", 32'(o_b_rvalid), 32'(ev_b));
                if (ev_a) begin hold_a = rq_a[0].data; void'(rq_a.pop_front()); end
                if (ev_b) begin hold_b = rq_b[0].data; void'(rq_b.pop_front()); end
                chk("a_rdata", 32'(o_a_rdata), 32'(hold_a));
                chk("b_rdata", 32'(o_b_rdata), 32'(hold_b));
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

`ifdef XIL_MEM_SP_ARB_CLEAR_EN
        push(0, 0, 2'b00, 10'd0, 18'h0);
        for (int i = 0; i < 600 && cyc < 500; i++) @(negedge clk);
        #1 rst = 1'b1;
        txq_a.delete(); txq_b.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("clr_restart_adr", 32'(o_mem_adr), 32'd0);
        chk("clr_restart_busy", 32'(o_busy), 32'd1);
        push(0, 0, 2'b00, 10'd0, 18'h0);
        push(1, 0, 2'b00, 10'd1023, 18'h0);
        wait_idle(1200);
        chk("clr_rd0", 32'(o_a_rdata), 32'(INIT));
        chk("clr_rd1023", 32'(o_b_rdata), 32'(INIT));
`endif

        // Full-word write then read on A
        push(0, 0, 2'b11, 10'd5, 18'h3FFFF);
        push(0, 2, 2'b00, 10'd5, 18'h0);
        wait_idle(100);
        chk("a_rd5", 32'(o_a_rdata), 32'h3FFFF);

        // Low-lane partial write then read on B
        push(1, 0, 2'b01, 10'd7, 18'h3FFFF);
        push(1, 0, 2'b00, 10'd7, 18'h0);
        wait_idle(100);
`ifdef XIL_MEM_SP_ARB_CLEAR_EN
        chk("b_rd7_partial", 32'(o_b_rdata), 32'h2ABFF);
`else
        chk("b_rd7_partial", 32'(o_b_rdata), 32'h001FF);
`endif

        // Both ports requesting back to back
        log_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(0, 0, 2'b00, 10'(i), 18'h0);
            push(1, 0, 2'b00, 10'(100 + i), 18'h0);
        end
        wait_idle(100);
        log_on = 1'b0;
        chk("rr_log_len", 32'(glog.size()), 32'd16);
        for (int i = 0; i < 8; i++) chk("rr_order", 32'(glog[i]), 32'(i % 2));

        // Write on A, read of same address on B the next cycle
        push(0, 0, 2'b11, 10'd1023, 18'h12345);
        push(1, 0, 2'b00, 10'd1023, 18'h0);
        wait_idle(100);
        chk("raw_1023", 32'(o_b_rdata), 32'h12345);

        // Random mixed traffic on a small address window
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++) begin
                push(p, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15)),
                     18'($urandom));
            end
        end
        wait_idle(3000);

        // Reset with reads still in flight
        for (int i = 0; i < 4; i++) begin
            push(0, 0, 2'b00, 10'(i), 18'h0);
            push(1, 0, 2'b00, 10'(i + 4), 18'h0);
        end
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        txq_a.delete(); txq_b.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("post_rst_a_rdata", 32'(o_a_rdata), 32'd0);
        chk("post_rst_b_rdata", 32'(o_b_rdata), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
